// File: rtl/count_display_pkg.sv
// Shared definitions for the seven-segment count display: digit count, converter
// states and the active-low segment table, ordered {g,f,e,d,c,b,a}.
package count_display_pkg;

    localparam int DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        UPDATE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [15:0] add3_nibbles(input logic [15:0] acc);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/count_display_bin2bcd_seq.sv
// Free-running sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// The result register only changes at the end of a complete conversion.
module count_display_bin2bcd_seq
    import count_display_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] bin,
    output logic [15:0]      bcd,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [WIDTH-1:0] sr;
    logic [15:0]      acc;
    logic [15:0]      acc_adj;
    logic [15:0]      acc_shifted;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    always_ff @(posedge clk) begin
        if (init) state <= IDLE;
        else      state <= state_next;
    end

    // UPDATE returns straight to LOAD so the steady-state loop is WIDTH+2 cycles;
    // IDLE is only passed through once after reset.
    always_comb begin
        acc_adj     = add3_nibbles(acc);
        acc_shifted = {acc_adj[14:0], sr[WIDTH-1]};
        last_bit    = (cnt == CW'(WIDTH - 1));
        state_next  = state;
        case (state)
            IDLE:    state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = UPDATE;
            UPDATE:  state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            sr   <= '0;
            acc  <= '0;
            cnt  <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    sr  <= bin;
                    acc <= '0;
                    cnt <= '0;
                end
                SHIFT: begin
                    acc <= acc_shifted;
                    sr  <= sr << 1;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        bcd  <= acc_shifted;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/count_display.sv
// Shows a binary count on a 4-digit multiplexed seven-segment display: BCD conversion,
// digit scan, leading-zero blanking and segment decode, all outputs registered.
module count_display
    import count_display_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] value_in,
    output logic [15:0]      bcd_out,
    output logic             conv_done,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic          tc;
    logic [3:0]    nib;
    logic [6:0]    seg_next;

    count_display_bin2bcd_seq #(
        .WIDTH(WIDTH)
    ) u_conv (
        .clk  (clk),
        .init (init),
        .bin  (value_in),
        .bcd  (bcd_out),
        .done (conv_done)
    );

    // Segments are decoded for the slot that becomes active on this edge, so an and
    // seg always switch together.
    always_comb begin
        tc       = (presc == PW'(SCAN_DIV - 1));
        idx_next = tc ? idx + 2'd1 : idx;
        nib      = bcd_out[{idx_next, 2'b00} +: 4];
        seg_next = seg_decode(nib);
        if (BLANK_LZ != 0 && idx_next != 2'd0 && (bcd_out >> {idx_next, 2'b00}) == 16'd0)
            seg_next = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= 4'b1110;
            seg   <= SEG_0;
            dp    <= 1'b1;
        end else begin
            presc <= tc ? '0 : presc + 1'b1;
            idx   <= idx_next;
            an    <= ~(4'b0001 << idx_next);
            seg   <= seg_next;
            dp    <= 1'b1;
        end
    end

endmodule
